// File: rtl/elastic_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Each stage advances independently when it is empty or its downstream neighbour advances.
module elastic_pipeline #(
  parameter int p_width = 32,
  parameter int p_depth = 3
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [p_width-1:0]               i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [p_width-1:0]               o_data,
  input  logic                             i_flush,
  output logic [$clog2(p_depth+1)-1:0]     o_count
);

  localparam int CW = $clog2(p_depth + 1);

  logic [p_depth-1:0] valid_q, valid_d;
  logic [p_depth-1:0] adv;
  logic [p_width-1:0] data_q [p_depth];
  logic [p_width-1:0] data_d [p_depth];

  // Stage k's input is chain element k: element 0 is the upstream port.
  logic [p_depth:0]   chain_v;
  logic [p_width-1:0] chain_d [p_depth+1];

  // Running OR from the output side: a stage may advance if it or any later stage
  // is empty, or the downstream sink is ready.
  always_comb begin : adv_chain
    logic free;
    adv  = '0;
    free = i_ready;
    for (int unsigned i = 0; i < p_depth; i++) begin
      free                 = free | ~valid_q[p_depth-1-i];
      adv[p_depth-1-i]     = free;
    end
  end

  always_comb begin
    chain_v    = {valid_q, i_valid};
    chain_d[0] = i_data;
    for (int unsigned k = 0; k < p_depth; k++) begin
      chain_d[k+1] = data_q[k];
    end

    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < p_depth; k++) begin
      if (adv[k]) begin
        valid_d[k] = chain_v[k];
        if (chain_v[k] && !i_flush) begin
          data_d[k] = chain_d[k];
        end
      end
    end
    if (i_flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < p_depth; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < p_depth; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int unsigned k = 0; k < p_depth; k++) begin
      o_count = o_count + CW'(valid_q[k]);
    end
  end

  assign o_ready = adv[0];
  assign o_valid = valid_q[p_depth-1];
  assign o_data  = data_q[p_depth-1];

endmodule
